// File: rtl/mips_pad_pkg.sv
// Shared types and helpers for the mips pad arbiter: channel ids, slot FSM states, parity.
package mips_pad_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {CH_PC = 1'b0, CH_ALU = 1'b1} chan_e;

  typedef enum logic [1:0] {IDLE, SEND, GAP} slot_state_e;

  function automatic logic even_par(input logic [DATA_W:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/mips_pad_fifo.sv
// Per-channel capture FIFO; a push to a full FIFO is kept only when a pop frees a slot that same cycle.
module mips_pad_fifo
  import mips_pad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              empty,
  output logic              full,
  output logic              drop,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  // Extra MSB on the pointers distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mips_pad_arbiter.sv
// Round-robin share of one 16-bit pad bus between the PC and ALU observation FIFOs.
// Optional registered parity pad enabled by defining PAD_PARITY_EN.
module mips_pad_arbiter
  import mips_pad_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              pc_cap,
  input  logic [DATA_W-1:0] alu_in,
  input  logic              alu_cap,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] pad_data,
  output logic              pad_sel,
  output logic              pad_valid,
  output logic              pc_ovf,
  output logic              alu_ovf
`ifdef PAD_PARITY_EN
  ,
  output logic              pad_par
`endif
);

  logic              pc_empty, pc_full, pc_drop, pc_pop;
  logic              alu_empty, alu_full, alu_drop, alu_pop;
  logic [DATA_W-1:0] pc_head, alu_head, head_mux;

  slot_state_e state, state_nxt;
  logic [3:0]  hold_cnt;
  chan_e       last_grant;
  chan_e       grant_ch;
  logic        grant_en;

  logic [DATA_W-1:0] data_q;
  logic              sel_q;

  mips_pad_fifo #(.DEPTH(DEPTH)) u_pc_fifo (
    .clk(clk), .reset(reset), .push(pc_cap), .pop(pc_pop), .din(pc_in),
    .empty(pc_empty), .full(pc_full), .drop(pc_drop), .head(pc_head)
  );

  mips_pad_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk(clk), .reset(reset), .push(alu_cap), .pop(alu_pop), .din(alu_in),
    .empty(alu_empty), .full(alu_full), .drop(alu_drop), .head(alu_head)
  );

  always_comb begin
    grant_en  = 1'b0;
    state_nxt = state;
    if (!pc_empty && !alu_empty)
      grant_ch = (last_grant == CH_ALU) ? CH_PC : CH_ALU;
    else
      grant_ch = (!alu_empty) ? CH_ALU : CH_PC;
    case (state)
      IDLE: begin
        if (!pc_empty || !alu_empty) begin
          grant_en  = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (hold_cnt == 4'd0) state_nxt = GAP;
      end
      // The gap cycle already does the idle grant so back-to-back words repeat every HOLD_CYCLES+1.
      GAP: begin
        if (!pc_empty || !alu_empty) begin
          grant_en  = 1'b1;
          state_nxt = SEND;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pc_pop   = grant_en && (grant_ch == CH_PC);
  assign alu_pop  = grant_en && (grant_ch == CH_ALU);
  assign head_mux = (grant_ch == CH_ALU) ? alu_head : pc_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= 4'd0;
      last_grant <= CH_ALU;
      pc_ovf     <= 1'b0;
      alu_ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_en) begin
        hold_cnt   <= 4'(HOLD_CYCLES - 1);
        last_grant <= grant_ch;
      end else if (state == SEND && hold_cnt != 4'd0) begin
        hold_cnt <= hold_cnt - 4'd1;
      end
      if (pc_drop)      pc_ovf <= 1'b1;
      else if (ovf_clr) pc_ovf <= 1'b0;
      if (alu_drop)     alu_ovf <= 1'b1;
      else if (ovf_clr) alu_ovf <= 1'b0;
    end
  end

  // Output word registers load on grant; the valid gating below hides their reset value.
  always_ff @(posedge clk) begin
    if (grant_en) begin
      data_q <= head_mux;
      sel_q  <= grant_ch;
    end
  end

  assign pad_valid = (state == SEND);
  assign pad_data  = pad_valid ? data_q : '0;
  assign pad_sel   = pad_valid & sel_q;

`ifdef PAD_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (grant_en) par_q <= even_par({grant_ch, head_mux});
  end

  assign pad_par = pad_valid & par_q;
`endif

endmodule

// File: tb/tb_mips_pad_arbiter.sv
// Directed self-checking bench for mips_pad_arbiter (DEPTH=4, HOLD_CYCLES=2).
module tb_mips_pad_arbiter;
  import mips_pad_pkg::*;

  localparam int HOLD = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] pc_in = '0;
  logic              pc_cap = 1'b0;
  logic [DATA_W-1:0] alu_in = '0;
  logic              alu_cap = 1'b0;
  logic              ovf_clr = 1'b0;
  logic [DATA_W-1:0] pad_data;
  logic              pad_sel;
  logic              pad_valid;
  logic              pc_ovf;
  logic              alu_ovf;
`ifdef PAD_PARITY_EN
  logic              pad_par;
`endif

  mips_pad_arbiter #(.DEPTH(4), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset),
    .pc_in(pc_in), .pc_cap(pc_cap),
    .alu_in(alu_in), .alu_cap(alu_cap),
    .ovf_clr(ovf_clr),
    .pad_data(pad_data), .pad_sel(pad_sel), .pad_valid(pad_valid),
    .pc_ovf(pc_ovf), .alu_ovf(alu_ovf)
`ifdef PAD_PARITY_EN
    , .pad_par(pad_par)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  logic [16:0] seen [$];
  int          seen_t [$];
  logic        prev_v = 1'b0;

  // Records each new word (rising pad_valid) with its cycle stamp.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (pad_valid && !prev_v) begin
      seen.push_back({pad_sel, pad_data});
      seen_t.push_back(cyc);
    end
    prev_v = pad_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    pc_cap  = 1'b0;
    alu_cap = 1'b0;
    ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen.delete();
    seen_t.delete();
  endtask

  // Waits for the next word, checks its latency, content, hold length and the trailing gap.
  task automatic expect_word(input string tag, input logic sel, input logic [15:0] data, input int lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pad_valid && n < 20);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_word"}, {15'd0, pad_valid, pad_sel, pad_data}, {15'd0, 1'b1, sel, data});
    for (int i = 1; i < HOLD; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {15'd0, pad_valid, pad_sel, pad_data}, {15'd0, 1'b1, sel, data});
    end
    @(negedge clk);
    chk({tag, "_gap"}, {15'd0, pad_valid, pad_sel, pad_data}, 32'd0);
  endtask

  initial begin
    logic [16:0] exp_w [7];
    logic [16:0] got_w;

    // Reset state
    do_reset();
    chk("rst_outputs", {27'd0, pad_valid, pad_sel, pc_ovf, alu_ovf, 1'b0}, 32'd0);
    chk("rst_data", {16'd0, pad_data}, 32'd0);

    // 1: single PC word, latency 2, held 2 cycles then 1-cycle gap
    @(negedge clk);
    pc_in = 16'h0040; pc_cap = 1'b1;
    @(negedge clk);
    pc_cap = 1'b0;
    expect_word("t1_pc", 1'b0, 16'h0040, 1);

    // 2: simultaneous captures, PC first then ALU 3 cycles later
    do_reset();
    pc_in = 16'h0004; alu_in = 16'h1234; pc_cap = 1'b1; alu_cap = 1'b1;
    @(negedge clk);
    pc_cap = 1'b0; alu_cap = 1'b0;
    expect_word("t2_pc", 1'b0, 16'h0004, 1);
    expect_word("t2_alu", 1'b1, 16'h1234, 1);
    chk("t2_ovf", {30'd0, pc_ovf, alu_ovf}, 32'd0);

    // 3: 8 back-to-back ALU captures; A006 hits a full FIFO with no pop and is dropped
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alu_in = 16'hA000 + 16'(i); alu_cap = 1'b1;
      @(negedge clk);
    end
    alu_cap = 1'b0;
    repeat (30) @(negedge clk);
    exp_w = '{{1'b1, 16'hA000}, {1'b1, 16'hA001}, {1'b1, 16'hA002}, {1'b1, 16'hA003},
              {1'b1, 16'hA004}, {1'b1, 16'hA005}, {1'b1, 16'hA007}};
    chk("t3_count", seen.size(), 7);
    for (int i = 0; i < 7; i++) begin
      got_w = (seen.size() > i) ? seen[i] : 17'h1FFFF;
      chk($sformatf("t3_word%0d", i), {15'd0, got_w}, {15'd0, exp_w[i]});
    end
    chk("t3_ovf", {30'd0, pc_ovf, alu_ovf}, 32'd1);
    repeat (5) @(negedge clk);
    chk("t3_ovf_sticky", {31'd0, alu_ovf}, 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", {31'd0, alu_ovf}, 32'd0);

    // 4: both channels backlogged -> strict alternation, 3-cycle period
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pc_in = 16'h1000 + 16'(i); alu_in = 16'h2000 + 16'(i);
      pc_cap = 1'b1; alu_cap = 1'b1;
      @(negedge clk);
    end
    pc_cap = 1'b0; alu_cap = 1'b0;
    repeat (40) @(negedge clk);
    chk("t4_count", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      got_w = seen[i];
      if (i % 2 == 0) chk($sformatf("t4_word%0d", i), {15'd0, got_w}, {16'd0, 16'h1000 + 16'(i/2)});
      else            chk($sformatf("t4_word%0d", i), {15'd0, got_w}, {16'd1, 16'h2000 + 16'(i/2)});
      if (i > 0) chk($sformatf("t4_period%0d", i), seen_t[i] - seen_t[i-1], 3);
    end
    chk("t4_ovf", {30'd0, pc_ovf, alu_ovf}, 32'd0);

    // 5: reset in mid-slot aborts the word and discards the queue
    do_reset();
    pc_in = 16'hBEEF; pc_cap = 1'b1;
    @(negedge clk);
    pc_in = 16'h1111;
    @(negedge clk);
    pc_cap = 1'b0;
    chk("t5_send", {15'd0, pad_valid, pad_data}, {16'd1, 16'hBEEF});
    reset = 1'b1;
    @(negedge clk);
    chk("t5_abort", {15'd0, pad_valid, pad_sel, pad_data}, 32'd0);
    reset = 1'b0;
    seen.delete();
    seen_t.delete();
    repeat (10) @(negedge clk);
    chk("t5_no_words", seen.size(), 0);

`ifdef PAD_PARITY_EN
    // 6: parity pad follows {pad_sel, pad_data}
    do_reset();
    pc_in = 16'h0007; pc_cap = 1'b1;
    @(negedge clk);
    pc_cap = 1'b0;
    chk("t6_par_idle", {31'd0, pad_par}, 32'd0);
    @(negedge clk);
    chk("t6_par_pc", {30'd0, pad_valid, pad_par}, 32'd3);
    repeat (2) @(negedge clk);
    chk("t6_par_gap", {30'd0, pad_valid, pad_par}, 32'd0);
    alu_in = 16'h0003; alu_cap = 1'b1;
    @(negedge clk);
    alu_cap = 1'b0;
    @(negedge clk);
    chk("t6_par_alu", {29'd0, pad_valid, pad_sel, pad_par}, 32'd7);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
